// File: rtl/serial_addsub_ctrl_311_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package serial_addsub_ctrl_311_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fa_cell_311.sv
// 1-bit full adder built from two half adders plus an OR on the carries.
module fa_cell_311 (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   logic s0, c0, c1;

   ha_311 u_ha0 (
      .a_i (a_i),
      .b_i (b_i),
      .s_o (s0),
      .c_o (c0)
   );

   ha_311 u_ha1 (
      .a_i (s0),
      .b_i (cin_i),
      .s_o (sum_o),
      .c_o (c1)
   );

   assign cout_o = c0 | c1;

endmodule

// File: rtl/ha_311.sv
// Half-adder cell: building block of the shared serial full adder.
module ha_311 (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_addsub_ctrl_311.sv
// Bit-serial add/subtract controller: one full-adder cell is reused for every
// bit position, LSB first, with the carry held in a flop between cycles.
module serial_addsub_ctrl_311
   import serial_addsub_ctrl_311_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk_311,
   input  logic             rst_n_311,
   input  logic             start_311,
   input  logic             sub_311,
   input  logic [WIDTH-1:0] a_311,
   input  logic [WIDTH-1:0] b_311,
   output logic             busy_311,
   output logic             done_311,
   output logic [WIDTH-1:0] s_311,
   output logic             c_311
);

   // Counter holds up to WIDTH so it never wraps inside an operation.
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             c_q, c_d;

   logic             accept, step, finish;
   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] sum_msb, res_next;

   fa_cell_311 u_fa (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .cin_i  (carry_q),
      .sum_o  (fa_sum),
      .cout_o (fa_cout)
   );

   // Sum bit enters at the MSB so that after WIDTH steps bit 0 lands at the LSB.
   always_comb begin
      sum_msb = '0;
      sum_msb[WIDTH-1] = fa_sum;
      res_next = (res_q >> 1) | sum_msb;
   end

   // Controller next-state and datapath strobes.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_311) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt_q == LAST) begin
               finish  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start_311) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state: load on accept, shift one bit per RUN cycle.
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      s_d     = s_q;
      c_d     = c_q;
      if (accept) begin
         a_sh_d  = a_311;
         // Subtraction is a + ~b + 1; the +1 rides in as the initial carry.
         b_sh_d  = sub_311 ? ~b_311 : b_311;
         carry_d = sub_311;
         cnt_d   = '0;
         res_d   = '0;
      end else if (step) begin
         a_sh_d  = a_sh_q >> 1;
         b_sh_d  = b_sh_q >> 1;
         carry_d = fa_cout;
         cnt_d   = cnt_q + CW'(1);
         res_d   = res_next;
         if (finish) begin
            s_d = res_next;
            c_d = fa_cout;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_311 or negedge rst_n_311) begin
      if (!rst_n_311) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   assign busy_311 = (state_q == ST_RUN);
   assign done_311 = (state_q == ST_DONE);
   assign s_311    = s_q;
   assign c_311    = c_q;

endmodule

// File: tb/tb_serial_addsub_ctrl_311.sv
// Self-checking bench for serial_addsub_ctrl_311 at WIDTH=8.
module tb_serial_addsub_ctrl_311;

   localparam int W = 8;
   localparam int LAT = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, c;
   logic [W-1:0] s;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] s;
      logic       c;
   } vec_t;

   vec_t vecs[9];

   serial_addsub_ctrl_311 #(
      .WIDTH (W)
   ) dut (
      .clk_311   (clk),
      .rst_n_311 (rst_n),
      .start_311 (start),
      .sub_311   (sub),
      .a_311     (a),
      .b_311     (b),
      .busy_311  (busy),
      .done_311  (done),
      .s_311     (s),
      .c_311     (c)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic; sub carry means "no borrow".
   function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic op_sub);
      logic [7:0] d;
      if (!op_sub) return {1'b0, x} + {1'b0, y};
      d = x - y;
      return {(x >= y), d};
   endfunction

   // Waits (bounded) for done; counts RUN cycles seen before it.
   task automatic wait_done(output int lat, output int busy_n);
      lat = 0;
      busy_n = 0;
      while (lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         if (busy) busy_n++;
      end
   endtask

   task automatic do_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                        input logic osub, input logic [7:0] es, input logic ec);
      int lat, busy_n;
      @(negedge clk);
      a = oa;
      b = ob;
      sub = osub;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble inputs while busy; the op in flight must not see them.
      a = 8'($urandom);
      b = 8'($urandom);
      sub = 1'($urandom);
      wait_done(lat, busy_n);
      busy_n += busy ? 0 : 1;
      chk({tag, " latency"}, lat, LAT);
      chk({tag, " busy_cycles"}, busy_n, LAT);
      chk({tag, " s"}, s, es);
      chk({tag, " c"}, c, ec);
      chk({tag, " busy_at_done"}, busy, 0);
      @(posedge clk);
      #1;
      chk({tag, " done_width"}, done, 0);
   endtask

   initial begin
      int lat, busy_n, done_cnt, first_done;
      logic [7:0] ra, rb, cap_s;
      logic rsub, cap_c;
      logic [8:0] m;

      vecs[0] = '{8'h3C, 8'h25, 1'b0, 8'h61, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
      vecs[3] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
      vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h01, 1'b0};
      vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h4B, 1'b1};

      // Reset state
      #12;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst s", s, 0);
      chk("rst c", c, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 9; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c);
      end

      // start pulsed mid-RUN must be ignored
      @(negedge clk);
      a = 8'h3C; b = 8'h25; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a = 8'h00; b = 8'h00; sub = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      done_cnt = 0;
      first_done = 0;
      cap_s = '0;
      cap_c = 1'b0;
      for (int k = 4; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_cnt++;
            if (first_done == 0) begin
               first_done = k;
               cap_s = s;
               cap_c = c;
            end
         end
      end
      chk("ign latency", first_done, LAT);
      chk("ign done_count", done_cnt, 1);
      chk("ign s", cap_s, 8'h61);
      chk("ign c", cap_c, 0);

      // Back-to-back: start held through DONE
      @(negedge clk);
      a = 8'h3C; b = 8'h25; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat, busy_n);
      chk("b2b first done", done, 1);
      chk("b2b first s", s, 8'h61);
      a = 8'h80; b = 8'h80; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b restart busy", busy, 1);
      chk("b2b restart done", done, 0);
      wait_done(lat, busy_n);
      chk("b2b latency", lat, LAT);
      chk("b2b s", s, 8'h00);
      chk("b2b c", c, 1);
      @(posedge clk);
      #1;
      chk("b2b done_width", done, 0);

      // Reset asserted mid-RUN (previous s is nonzero from the table)
      do_op("pre_rst", 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0);
      @(negedge clk);
      a = 8'h77; b = 8'h11; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst s", s, 0);
      chk("midrst c", c, 0);
      done_cnt = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      chk("midrst no_done", done_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_rst", 8'h77, 8'h11, 1'b0, 8'h88, 1'b0);

      // Randomized ops against the arithmetic model
      for (int i = 0; i < 1500; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rsub = 1'($urandom);
         if (i < 4) begin
            ra = (i[0]) ? 8'hFF : 8'h00;
            rb = (i[1]) ? 8'hFF : 8'h00;
         end
         m = model(ra, rb, rsub);
         do_op($sformatf("rnd%0d", i), ra, rb, rsub, m[7:0], m[8]);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
